// File: rtl/rasterizer_mem_arbiter.sv
// Purpose: merge NUM_PORTS Avalon-MM clients onto one SDRAM master, routing read data back in issue order.
// Latency: command 0 cycles (combinational grant), read return 0 cycles (ID FIFO head steers readdatavalid).
// Backpressure: m_waitrequest or a full ID FIFO stalls the granted port; every other port sees waitrequest = 1.
module rasterizer_mem_arbiter #(
    parameter int NUM_PORTS   = 3,
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 8,
    parameter int ARB_MODE    = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_PORTS*ADDR_W-1:0]   s_address,
    input  logic [NUM_PORTS-1:0]          s_read,
    input  logic [NUM_PORTS-1:0]          s_write,
    input  logic [NUM_PORTS*DATA_W/8-1:0] s_byteenable,
    input  logic [NUM_PORTS*DATA_W-1:0]   s_writedata,
    output logic [NUM_PORTS-1:0]          s_waitrequest,
    output logic [DATA_W-1:0]             s_readdata,
    output logic [NUM_PORTS-1:0]          s_readdatavalid,
    output logic [ADDR_W-1:0]             m_address,
    output logic                          m_read,
    output logic                          m_write,
    output logic [DATA_W/8-1:0]           m_byteenable,
    output logic [DATA_W-1:0]             m_writedata,
    input  logic                          m_waitrequest,
    input  logic [DATA_W-1:0]             m_readdata,
    input  logic                          m_readdatavalid,
    output logic [$clog2(MAX_PENDING):0]  pending_count,
    output logic                          err_orphan
);
    localparam int BE_W = DATA_W / 8;
    localparam int IDW  = $clog2(NUM_PORTS);
    localparam int AW   = $clog2(MAX_PENDING);
    localparam int PW   = AW + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state;
    logic [IDW-1:0]    lock_id;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    fifo_mem [MAX_PENDING];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [PW-1:0]     count;

    logic [ADDR_W-1:0] addr_a [NUM_PORTS];
    logic [BE_W-1:0]   be_a   [NUM_PORTS];
    logic [DATA_W-1:0] wd_a   [NUM_PORTS];

    logic [NUM_PORTS-1:0] req;
    logic [IDW-1:0]       grant;
    logic [IDW-1:0]       cand;
    logic [IDW-1:0]       next_ptr;
    logic                 grant_vld;
    logic                 grant_rd;
    logic                 grant_wr;
    logic                 full;
    logic                 issue;
    logic                 accept;
    logic                 push;
    logic                 pop;
    int                   pos;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign addr_a[i] = s_address[i*ADDR_W +: ADDR_W];
        assign be_a[i]   = s_byteenable[i*BE_W +: BE_W];
        assign wd_a[i]   = s_writedata[i*DATA_W +: DATA_W];
    end

    assign req = s_read | s_write;

    // Scan order starts at rr_ptr for round-robin, at port 0 for fixed priority.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand      = '0;
        pos       = 0;
        if (state == LOCKED) begin
            grant     = lock_id;
            grant_vld = req[lock_id];
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                pos = (ARB_MODE == 0) ? int'(rr_ptr) + i : i;
                if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
                cand = pos[IDW-1:0];
                if (!grant_vld && req[cand]) begin
                    grant     = cand;
                    grant_vld = 1'b1;
                end
            end
        end
    end

    assign full     = (count == PW'(MAX_PENDING));
    assign grant_rd = s_read[grant];
    assign grant_wr = s_write[grant] & ~grant_rd;
    // A read held off by a full FIFO must not reach the bus at all.
    assign issue    = grant_vld & reset & ~(grant_rd & full);
    assign accept   = issue & ~m_waitrequest;
    assign push     = accept & grant_rd;
    assign pop      = m_readdatavalid & (count != '0);
    assign next_ptr = (grant == IDW'(NUM_PORTS - 1)) ? '0 : grant + IDW'(1);

    assign m_read        = issue & grant_rd;
    assign m_write       = issue & grant_wr;
    assign m_address     = addr_a[grant];
    assign m_byteenable  = be_a[grant];
    assign m_writedata   = wd_a[grant];
    assign s_waitrequest = accept ? ~(NUM_PORTS'(1) << grant) : '1;

    assign s_readdata      = m_readdata;
    assign s_readdatavalid = pop ? (NUM_PORTS'(1) << fifo_mem[rd_ptr]) : '0;
    assign pending_count   = count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            lock_id <= '0;
            rr_ptr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rr_ptr <= next_ptr;
                    end else if (grant_vld) begin
                        lock_id <= grant;
                        state   <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (!req[lock_id]) begin
                        state <= IDLE;
                    end else if (accept) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
            if (m_readdatavalid && count == '0) err_orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rasterizer_mem_arbiter.sv
// Directed bench: round-robin instance carries most scenarios, a fixed-priority instance shares its inputs.
module tb_rasterizer_mem_arbiter;
    logic        clock;
    logic        reset;
    logic [77:0] s_address;
    logic [2:0]  s_read;
    logic [2:0]  s_write;
    logic [11:0] s_byteenable;
    logic [95:0] s_writedata;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;

    logic [2:0]  s_waitrequest, s_readdatavalid;
    logic [31:0] s_readdata, m_writedata;
    logic [25:0] m_address;
    logic        m_read, m_write, err_orphan;
    logic [3:0]  m_byteenable;
    logic [3:0]  pending_count;

    logic [2:0]  fp_s_waitrequest, fp_s_readdatavalid;
    logic [31:0] fp_s_readdata, fp_m_writedata;
    logic [25:0] fp_m_address;
    logic        fp_m_read, fp_m_write, fp_err_orphan;
    logic [3:0]  fp_m_byteenable;
    logic [3:0]  fp_pending_count;

    int passed = 0;
    int total  = 0;

    logic [25:0] addr_tab [3];
    logic [31:0] data_tab [3];

    rasterizer_mem_arbiter #(.NUM_PORTS(3), .ADDR_W(26), .DATA_W(32), .MAX_PENDING(8), .ARB_MODE(0)) u_rr (
        .clock(clock), .reset(reset), .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_byteenable(s_byteenable), .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid), .m_address(m_address),
        .m_read(m_read), .m_write(m_write), .m_byteenable(m_byteenable), .m_writedata(m_writedata),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .pending_count(pending_count), .err_orphan(err_orphan)
    );

    rasterizer_mem_arbiter #(.NUM_PORTS(3), .ADDR_W(26), .DATA_W(32), .MAX_PENDING(8), .ARB_MODE(1)) u_fp (
        .clock(clock), .reset(reset), .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_byteenable(s_byteenable), .s_writedata(s_writedata), .s_waitrequest(fp_s_waitrequest),
        .s_readdata(fp_s_readdata), .s_readdatavalid(fp_s_readdatavalid), .m_address(fp_m_address),
        .m_read(fp_m_read), .m_write(fp_m_write), .m_byteenable(fp_m_byteenable), .m_writedata(fp_m_writedata),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .pending_count(fp_pending_count), .err_orphan(fp_err_orphan)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic clear_inputs;
        s_read          = '0;
        s_write         = '0;
        m_waitrequest   = 1'b0;
        m_readdatavalid = 1'b0;
        m_readdata      = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        s_read = 3'b111;
        m_readdatavalid = 1'b1;
        settle();
        total++; if (m_read !== 1'b0) $display("FAIL reset_m_read got %b want 0", m_read); else passed++;
        total++; if (m_write !== 1'b0) $display("FAIL reset_m_write got %b want 0", m_write); else passed++;
        total++; if (s_waitrequest !== 3'b111) $display("FAIL reset_waitreq got %b want 111", s_waitrequest); else passed++;
        total++; if (s_readdatavalid !== 3'b000) $display("FAIL reset_rdv got %b want 000", s_readdatavalid); else passed++;
        total++; if (pending_count !== 4'd0) $display("FAIL reset_pending got %0d want 0", pending_count); else passed++;
        total++; if (err_orphan !== 1'b0) $display("FAIL reset_orphan got %b want 0", err_orphan); else passed++;
        tick();
        clear_inputs();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_read_return;
        s_read = 3'b010;
        settle();
        total++; if (m_read !== 1'b1) $display("FAIL rd_m_read got %b want 1", m_read); else passed++;
        total++; if (m_address !== 26'h0000100) $display("FAIL rd_addr got %h want 0000100", m_address); else passed++;
        total++; if (s_waitrequest !== 3'b101) $display("FAIL rd_waitreq got %b want 101", s_waitrequest); else passed++;
        tick();
        s_read = '0;
        settle();
        total++; if (pending_count !== 4'd1) $display("FAIL rd_pending1 got %0d want 1", pending_count); else passed++;
        tick();
        tick();
        m_readdatavalid = 1'b1;
        m_readdata = 32'hDEADBEEF;
        settle();
        total++; if (s_readdatavalid !== 3'b010) $display("FAIL rd_rdv got %b want 010", s_readdatavalid); else passed++;
        total++; if (s_readdata !== 32'hDEADBEEF) $display("FAIL rd_data got %h want deadbeef", s_readdata); else passed++;
        tick();
        m_readdatavalid = 1'b0;
        settle();
        total++; if (pending_count !== 4'd0) $display("FAIL rd_pending0 got %0d want 0", pending_count); else passed++;
    endtask

    task automatic test_push_pop;
        tick();
        s_read = 3'b001;
        settle();
        tick();
        m_readdatavalid = 1'b1;
        settle();
        total++; if (s_readdatavalid !== 3'b001) $display("FAIL pp_rdv got %b want 001", s_readdatavalid); else passed++;
        total++; if (s_waitrequest !== 3'b110) $display("FAIL pp_waitreq got %b want 110", s_waitrequest); else passed++;
        tick();
        s_read = '0;
        m_readdatavalid = 1'b0;
        settle();
        total++; if (pending_count !== 4'd1) $display("FAIL pp_pending got %0d want 1", pending_count); else passed++;
        tick();
        m_readdatavalid = 1'b1;
        settle();
        tick();
        m_readdatavalid = 1'b0;
        settle();
        total++; if (pending_count !== 4'd0) $display("FAIL pp_drain got %0d want 0", pending_count); else passed++;
    endtask

    task automatic test_rr_writes;
        logic [2:0] exp_wr;
        do_reset();
        s_write = 3'b111;
        for (int k = 0; k < 4; k++) begin
            exp_wr = ~(3'b001 << (k % 3));
            settle();
            total++; if (s_waitrequest !== exp_wr) $display("FAIL rr_waitreq%0d got %b want %b", k, s_waitrequest, exp_wr); else passed++;
            total++; if (m_address !== addr_tab[k % 3]) $display("FAIL rr_addr%0d got %h want %h", k, m_address, addr_tab[k % 3]); else passed++;
            total++; if (m_writedata !== data_tab[k % 3]) $display("FAIL rr_wdata%0d got %h want %h", k, m_writedata, data_tab[k % 3]); else passed++;
            tick();
        end
        s_write = '0;
    endtask

    task automatic test_locked_stall;
        s_read = 3'b100;
        m_waitrequest = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) s_write = 3'b001;
            settle();
            total++; if (m_address !== addr_tab[2]) $display("FAIL lk_addr%0d got %h want %h", c, m_address, addr_tab[2]); else passed++;
            total++; if (m_read !== 1'b1) $display("FAIL lk_m_read%0d got %b want 1", c, m_read); else passed++;
            total++; if (s_waitrequest !== 3'b111) $display("FAIL lk_waitreq%0d got %b want 111", c, s_waitrequest); else passed++;
            tick();
        end
        m_waitrequest = 1'b0;
        settle();
        total++; if (s_waitrequest !== 3'b011) $display("FAIL lk_accept2 got %b want 011", s_waitrequest); else passed++;
        tick();
        s_read = '0;
        settle();
        total++; if (s_waitrequest !== 3'b110) $display("FAIL lk_accept0 got %b want 110", s_waitrequest); else passed++;
        total++; if (m_address !== addr_tab[0]) $display("FAIL lk_addr0 got %h want %h", m_address, addr_tab[0]); else passed++;
        total++; if (m_write !== 1'b1) $display("FAIL lk_m_write got %b want 1", m_write); else passed++;
        tick();
        s_write = '0;
        m_readdatavalid = 1'b1;
        settle();
        total++; if (s_readdatavalid !== 3'b100) $display("FAIL lk_rdv got %b want 100", s_readdatavalid); else passed++;
        tick();
        m_readdatavalid = 1'b0;
    endtask

    task automatic test_fifo_full;
        s_read = 3'b010;
        for (int k = 0; k < 8; k++) begin
            settle();
            total++; if (s_waitrequest !== 3'b101) $display("FAIL ff_issue%0d got %b want 101", k, s_waitrequest); else passed++;
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            settle();
            total++; if (pending_count !== 4'd8) $display("FAIL ff_pending%0d got %0d want 8", k, pending_count); else passed++;
            total++; if (s_waitrequest !== 3'b111) $display("FAIL ff_block%0d got %b want 111", k, s_waitrequest); else passed++;
            total++; if (m_read !== 1'b0) $display("FAIL ff_m_read%0d got %b want 0", k, m_read); else passed++;
            tick();
        end
        m_readdatavalid = 1'b1;
        settle();
        total++; if (s_waitrequest !== 3'b111) $display("FAIL ff_popblock got %b want 111", s_waitrequest); else passed++;
        total++; if (s_readdatavalid !== 3'b010) $display("FAIL ff_poprdv got %b want 010", s_readdatavalid); else passed++;
        tick();
        m_readdatavalid = 1'b0;
        settle();
        total++; if (s_waitrequest !== 3'b101) $display("FAIL ff_unblock got %b want 101", s_waitrequest); else passed++;
        total++; if (pending_count !== 4'd7) $display("FAIL ff_pending7 got %0d want 7", pending_count); else passed++;
        tick();
        s_read = '0;
        settle();
        total++; if (pending_count !== 4'd8) $display("FAIL ff_refill got %0d want 8", pending_count); else passed++;
        for (int k = 0; k < 8; k++) begin
            m_readdatavalid = 1'b1;
            settle();
            total++; if (s_readdatavalid !== 3'b010) $display("FAIL ff_drain%0d got %b want 010", k, s_readdatavalid); else passed++;
            tick();
        end
        m_readdatavalid = 1'b0;
        settle();
        total++; if (pending_count !== 4'd0) $display("FAIL ff_empty got %0d want 0", pending_count); else passed++;
        total++; if (err_orphan !== 1'b0) $display("FAIL ff_orphan got %b want 0", err_orphan); else passed++;
    endtask

    task automatic test_fixed_priority;
        do_reset();
        s_write = 3'b101;
        for (int k = 0; k < 10; k++) begin
            settle();
            total++; if (fp_s_waitrequest !== 3'b110) $display("FAIL fp_port0_%0d got %b want 110", k, fp_s_waitrequest); else passed++;
            tick();
        end
        s_write = 3'b100;
        settle();
        total++; if (fp_s_waitrequest !== 3'b011) $display("FAIL fp_port2 got %b want 011", fp_s_waitrequest); else passed++;
        total++; if (fp_m_address !== addr_tab[2]) $display("FAIL fp_addr2 got %h want %h", fp_m_address, addr_tab[2]); else passed++;
        tick();
        s_write = '0;
    endtask

    task automatic test_reset_orphan;
        s_read = 3'b001;
        for (int k = 0; k < 3; k++) begin
            settle();
            tick();
        end
        s_read = '0;
        settle();
        total++; if (pending_count !== 4'd3) $display("FAIL or_pending3 got %0d want 3", pending_count); else passed++;
        reset = 1'b0;
        settle();
        total++; if (pending_count !== 4'd0) $display("FAIL or_cleared got %0d want 0", pending_count); else passed++;
        tick();
        reset = 1'b1;
        m_readdatavalid = 1'b1;
        settle();
        total++; if (s_readdatavalid !== 3'b000) $display("FAIL or_rdv got %b want 000", s_readdatavalid); else passed++;
        tick();
        m_readdatavalid = 1'b0;
        settle();
        total++; if (err_orphan !== 1'b1) $display("FAIL or_flag got %b want 1", err_orphan); else passed++;
        total++; if (pending_count !== 4'd0) $display("FAIL or_pending0 got %0d want 0", pending_count); else passed++;
    endtask

    initial begin
        addr_tab[0] = 26'h0000A00; addr_tab[1] = 26'h0000100; addr_tab[2] = 26'h3FFFFC0;
        data_tab[0] = 32'h11110000; data_tab[1] = 32'h22221111; data_tab[2] = 32'h33332222;
        s_address    = '0;
        s_writedata  = '0;
        s_byteenable = '0;
        for (int p = 0; p < 3; p++) begin
            s_address[p*26 +: 26]  = addr_tab[p];
            s_writedata[p*32 +: 32] = data_tab[p];
            s_byteenable[p*4 +: 4]  = 4'hF;
        end
        clear_inputs();
        reset = 1'b0;
        tick();
        test_reset();
        test_read_return();
        test_push_pop();
        test_rr_writes();
        test_locked_stall();
        test_fifo_full();
        test_fixed_priority();
        test_reset_orphan();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
